carry_chain_sequencer: RTL and testbench
========================================

Name: carry_chain_sequencer

Overview:
Operand/result staging around the tile's combinational full_adder, which has no clock. It accepts a multi-word add as a stream of WIDTH-bit chunks, LSB chunk first. Each chunk is registered and driven to the adder. The adder's carry_out is chained into the next chunk's carry_in, and each sum chunk is registered onto a valid/ready output stream. The tile top instantiates this block next to full_adder; the adder is not instantiated inside it.

Parameters:
WIDTH, 16, chunk width; must match full_adder width
MAX_WORDS, 4, maximum chunks per operation before the chain is forcibly restarted
IDX_W, $clog2(MAX_WORDS), width of the chunk index

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  chunk available
in_ready  out  1  chunk accepted when in_valid&&in_ready
in_a  in  WIDTH  operand A chunk
in_b  in  WIDTH  operand B chunk
in_first  in  1  chunk is LSB chunk of a new operation
in_last  in  1  chunk is MSB chunk of the operation
add_a  out  WIDTH  to adder a
add_b  out  WIDTH  to adder b
add_carry_in  out  1  to adder carry_in
add_carry_listen  out  1  to adder carry_listen
add_on_off  out  1  to adder on_off
add_c  in  WIDTH  from adder c
add_carry_out  in  1  from adder carry_out
add_ack  in  1  from adder ack
out_valid  out  1  result chunk valid
out_ready  in  1  downstream accepts
out_sum  out  WIDTH  sum chunk
out_carry  out  1  carry out of this chunk; final carry when out_last
out_last  out  1  MSB chunk of the operation
out_idx  out  IDX_W  chunk index within the operation (0 = LSB)
err_seq  out  1  sticky protocol-error flag

Behaviour:
- Reset (sync, active-high) has priority over everything.
  - Next edge: every output is 0 and the FSM is IDLE.
  - Stage registers, carry register and chunk counter are cleared.
  - err_seq is cleared.
  - A reset in the middle of an operation discards that operation.
- Two register stages:
  - S1 holds the operand chunk.
  - S2 holds the result chunk.
- Adder drive, combinational from S1:
  - add_on_off = s1_valid.
  - add_a/add_b = S1 operands.
  - add_carry_listen = s1_valid && !s1_first.
  - add_carry_in = carry_q.
  - When S1 is empty: on_off=0, a/b/carry_in/listen = 0.
- Commit condition: commit = s1_valid && add_ack && (!out_valid || out_ready). On commit:
  - S2 <= {add_c, add_carry_out, s1_last, s1_idx}.
  - carry_q <= add_carry_out.
  - out_valid <= 1.
- Output pop: out_valid && out_ready && !commit sets out_valid <= 0.
- Handshakes:
  - in_ready = !reset && (!s1_valid || commit).
  - Pop and commit in the same cycle are allowed, giving full throughput of 1 chunk/clk.
- Latency: a chunk accepted on edge T is presented to the adder during cycle T. Its result is registered on edge T+1, so out_valid is high from T+1 when S2 is free.
- Backpressure: while out_valid && !out_ready, S2 holds, S1 holds, and in_ready is low. carry_q is unchanged, so no chunk is lost or duplicated.
- add_ack low with S1 valid: stall. No commit occurs and S1 holds.
- FSM, evaluated on each accepted chunk:
  - IDLE: a chunk with in_first marks s1_first=1 and sets idx=0. A chunk without in_first is treated as first and sets err_seq.
  - After acceptance, go to IDLE if in_last, else BUSY.
  - BUSY: a chunk without in_first gets idx = previous+1 and s1_first=0.
  - BUSY, chunk with in_first: sets err_seq; the chain restarts with that chunk as first.
  - BUSY, chunk that would be index MAX_WORDS: sets err_seq; the chunk is forced to first (idx=0, no carry chained).
- in_first && in_last on the same chunk is a legal single-chunk operation.
- Width rule: the carry chains only through carry_q, one bit. Sums wrap modulo 2^WIDTH per chunk.

Decomposition:
- Package cgra_tile_pkg holds:
  - localparam DATA_W=16.
  - typedef enum logic {SEQ_IDLE, SEQ_BUSY} seq_state_t.
  - typedef struct packed {sum, carry, last, idx} for the S2 result.
- No sub-module. S1/S2 plus the FSM stay in one file. The tile top wires this block to full_adder.

Test Plan:
1. Single chunk, first=last=1, a=0xFFFF, b=0x0001 -> add_carry_listen=0; out_sum=0x0000, out_carry=1, out_last=1, out_idx=0, out_valid one edge after accept.
2. 48-bit add, 3 chunks: a={0xFFFF,0xFFFF,0x0000}, b={0x0001,0x0000,0x0000} -> sums 0x0000/0x0000/0x0001, carries 1/1/0, carry_listen 0/1/1, back-to-back at 1 chunk/clk.
3. Same as 2 with out_ready=0 for 3 cycles after the first result -> in_ready low while S1 and S2 are full; results are identical to 2 with no drop or duplicate; carry chain preserved.
4. Protocol errors -> err_seq=1, stays high until reset; restarted chunk uses carry_listen=0:
   - in_first asserted on the 2nd chunk of a running operation;
   - separately, a non-first chunk sent while IDLE.
5. Reset asserted for 1 cycle after chunk 2 of 3 -> next edge: out_valid=0, outputs 0, err_seq=0; the following chunk with in_first=1, a=0x0003, b=0x0004 -> out_sum=0x0007, out_idx=0.
6. MAX_WORDS=4, 5 chunks without in_last, all a=0xFFFF, b=0x0001 -> idx 0,1,2,3 then 0; 5th chunk carry_listen=0 and sum=0x0000 carry=1; err_seq=1.

Source files
------------

// File: rtl/cgra_tile_pkg.sv
// -----------------------------------------------------------------------------
// cgra_tile_pkg
// Shared types and constants for the CGRA tile datapath blocks.
//   DATA_W        : datapath chunk width, shared with full_adder
//   SEQ_MAX_WORDS : default maximum chunks per chained add
//   SEQ_IDX_W     : chunk index width for SEQ_MAX_WORDS
//   seq_state_t   : carry_chain_sequencer operation tracking state
//   seq_result_t  : one registered result chunk (sum, carry, last, idx)
// -----------------------------------------------------------------------------
package cgra_tile_pkg;

   localparam int DATA_W        = 16;
   localparam int SEQ_MAX_WORDS = 4;
   localparam int SEQ_IDX_W     = $clog2(SEQ_MAX_WORDS);

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_BUSY = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic [DATA_W-1:0]    sum;
      logic                 carry;
      logic                 last;
      logic [SEQ_IDX_W-1:0] idx;
   } seq_result_t;

endpackage

// File: rtl/carry_chain_sequencer.sv
// -----------------------------------------------------------------------------
// carry_chain_sequencer
// Stages a multi-word add, LSB chunk first, around the tile's combinational
// full_adder (instantiated beside this block by the tile top). S1 holds the
// operand chunk and drives the adder; S2 holds the registered sum chunk on a
// valid/ready output stream. The adder's carry_out is kept in carry_q and fed
// back as carry_in for the next chunk of the same operation.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its data steady until that edge; ready may
// depend combinationally on the consumer's ready (in_ready follows out_ready
// through the commit term) but never on in_valid.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand chunk stream (in_a, in_b, in_first, in_last)
//   add_a/add_b         : operands to full_adder
//   add_carry_in        : chained carry to full_adder
//   add_carry_listen    : full_adder uses carry_in only when high
//   add_on_off          : full_adder enable (S1 occupied)
//   add_c/add_carry_out : full_adder sum and carry
//   add_ack             : full_adder result is valid
//   out_valid/out_ready : result chunk stream (out_sum, out_carry, out_last,
//                         out_idx)
//   err_seq             : sticky chunk-sequencing error, cleared by reset
// -----------------------------------------------------------------------------
module carry_chain_sequencer
   import cgra_tile_pkg::*;
#(
   parameter int WIDTH     = DATA_W,
   parameter int MAX_WORDS = SEQ_MAX_WORDS,
   parameter int IDX_W     = $clog2(MAX_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_first,
   input  logic             in_last,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_carry_in,
   output logic             add_carry_listen,
   output logic             add_on_off,
   input  logic [WIDTH-1:0] add_c,
   input  logic             add_carry_out,
   input  logic             add_ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_last,
   output logic [IDX_W-1:0] out_idx,
   output logic             err_seq
);

   // Index of the last chunk an operation may hold before the chain restarts.
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_WORDS - 1);

   // Operation tracking
   seq_state_t       state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;      // index of the last accepted chunk
   logic             err_q, err_d;

   // S1: operand chunk
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_first_q, s1_first_d;
   logic             s1_last_q, s1_last_d;
   logic [IDX_W-1:0] s1_idx_q, s1_idx_d;

   // Carry chain and S2 result
   logic             carry_q, carry_d;
   seq_result_t      s2_q, s2_d;
   logic             out_valid_q, out_valid_d;

   logic             commit;
   logic             accept;
   logic             chunk_first;
   logic [IDX_W-1:0] chunk_idx;
   logic             chunk_err;

   // S2 can take the adder result when empty or being drained this cycle.
   assign commit   = s1_valid_q && add_ack && (!out_valid_q || out_ready);
   assign in_ready = !reset && (!s1_valid_q || commit);
   assign accept   = in_valid && in_ready;

   // Adder drive; everything is held at zero while S1 is empty.
   assign add_on_off       = s1_valid_q;
   assign add_a            = s1_valid_q ? s1_a_q : '0;
   assign add_b            = s1_valid_q ? s1_b_q : '0;
   assign add_carry_listen = s1_valid_q && !s1_first_q;
   assign add_carry_in     = s1_valid_q && carry_q;

   assign out_valid = out_valid_q;
   assign out_sum   = s2_q.sum;
   assign out_carry = s2_q.carry;
   assign out_last  = s2_q.last;
   assign out_idx   = s2_q.idx;
   assign err_seq   = err_q;

   // Classify the chunk on the input port. Any sequencing violation restarts
   // the chain with this chunk as a fresh LSB chunk (idx 0, carry ignored).
   always_comb begin
      chunk_first = 1'b1;
      chunk_idx   = '0;
      chunk_err   = 1'b0;
      case (state_q)
         SEQ_IDLE: chunk_err = !in_first;
         SEQ_BUSY: begin
            if (in_first || cnt_q == IDX_MAX) begin
               chunk_err = 1'b1;
            end else begin
               chunk_first = 1'b0;
               chunk_idx   = cnt_q + IDX_W'(1);
            end
         end
         default: chunk_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_first_d  = s1_first_q;
      s1_last_d   = s1_last_q;
      s1_idx_d    = s1_idx_q;
      carry_d     = carry_q;
      s2_d        = s2_q;
      out_valid_d = out_valid_q;

      // S2 side first: a commit overrides a pop in the same cycle.
      if (commit) begin
         s2_d.sum    = add_c;
         s2_d.carry  = add_carry_out;
         s2_d.last   = s1_last_q;
         s2_d.idx    = s1_idx_q;
         carry_d     = add_carry_out;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // S1 side: a new chunk may replace the one committing this cycle.
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
         s1_first_d = chunk_first;
         s1_last_d  = in_last;
         s1_idx_d   = chunk_idx;
         cnt_d      = chunk_idx;
         err_d      = err_q || chunk_err;
         state_d    = in_last ? SEQ_IDLE : SEQ_BUSY;
      end else if (commit) begin
         s1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SEQ_IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_idx_q    <= '0;
         carry_q     <= 1'b0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s1_idx_q    <= s1_idx_d;
         carry_q     <= carry_d;
         s2_q        <= s2_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_carry_chain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_carry_chain_sequencer
// Drives chunk streams into carry_chain_sequencer with a behavioural
// full_adder beside it. The reference model works per operation with plain
// arithmetic: it tracks the chunk position within the running add and the
// carry of the previous chunk, and predicts each result chunk, the adder
// drive, the handshake outputs and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_carry_chain_sequencer;

   localparam int W     = 16;
   localparam int MAXW  = 4;
   localparam int IW    = 2;
   localparam int RES_W = W + 2 + IW;   // {sum, carry, last, idx}
   localparam int DRV_W = 2 * W + 2;    // {a, b, listen, carry_in}
   localparam int CH_W  = 2 * W + 2;    // {a, b, first, last}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_first;
   logic          in_last;
   logic [W-1:0]  add_a;
   logic [W-1:0]  add_b;
   logic          add_carry_in;
   logic          add_carry_listen;
   logic          add_on_off;
   logic [W-1:0]  add_c;
   logic          add_carry_out;
   logic          add_ack;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_carry;
   logic          out_last;
   logic [IW-1:0] out_idx;
   logic          err_seq;

   carry_chain_sequencer #(.WIDTH(W), .MAX_WORDS(MAXW)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .in_first         (in_first),
      .in_last          (in_last),
      .add_a            (add_a),
      .add_b            (add_b),
      .add_carry_in     (add_carry_in),
      .add_carry_listen (add_carry_listen),
      .add_on_off       (add_on_off),
      .add_c            (add_c),
      .add_carry_out    (add_carry_out),
      .add_ack          (add_ack),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_sum          (out_sum),
      .out_carry        (out_carry),
      .out_last         (out_last),
      .out_idx          (out_idx),
      .err_seq          (err_seq)
   );

   // Behavioural full_adder: carry_in counts only when carry_listen is high.
   logic       ack_rand;
   logic [W:0] adder_full;
   assign adder_full    = {1'b0, add_a} + {1'b0, add_b}
                        + {{W{1'b0}}, add_carry_listen & add_carry_in};
   assign add_c         = add_on_off ? adder_full[W-1:0] : '0;
   assign add_carry_out = add_on_off & adder_full[W];
   assign add_ack       = add_on_off & ack_rand;

   // ---------------- reference model state ----------------
   logic [CH_W-1:0]  send_q[$];
   logic [RES_W-1:0] exp_q[$];
   logic [DRV_W-1:0] drv_q[$];
   int   s1_cnt, s2_cnt;
   bit   m_busy, m_carry, m_err;
   int   m_next_idx;
   int   acc_total;
   bit   pending;
   int   valid_pct, ready_pct, ack_pct;
   int   hold_len, hold_left;
   bit   hold_armed;
   int   n_vec, n_err;

   // ---------------- scoreboard check ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Predict the result of an accepted chunk from the operation rules.
   task automatic model_accept(input logic [CH_W-1:0] ch);
      logic [W-1:0] a, b;
      logic         f, l, cin;
      bit           first;
      int           idx;
      logic [W:0]   full;
      {a, b, f, l} = ch;
      first = 1'b0;
      if (!m_busy) begin
         first = 1'b1;
         if (!f) m_err = 1'b1;
      end else if (f || m_next_idx == MAXW) begin
         first = 1'b1;
         m_err = 1'b1;
      end
      idx  = first ? 0 : m_next_idx;
      cin  = first ? 1'b0 : m_carry;
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      exp_q.push_back({full[W-1:0], full[W], l, IW'(idx)});
      drv_q.push_back({a, b, (first ? 1'b0 : 1'b1), m_carry});
      m_carry    = full[W];
      m_next_idx = idx + 1;
      m_busy     = !l;
      acc_total++;
   endtask

   task automatic push_chunk(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic f, input logic l);
      send_q.push_back({a, b, f, l});
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle();
      logic             commit, pop, exp_rdy;
      logic [DRV_W-1:0] d;
      logic [RES_W-1:0] r;
      @(negedge clk);
      check_eq("err_seq", err_seq, m_err);
      check_eq("out_valid", out_valid, s2_cnt != 0);
      if (!pending && send_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
         {in_a, in_b, in_first, in_last} = send_q.pop_front();
         pending = 1'b1;
      end else if (!pending) begin
         in_a     = W'($urandom);
         in_b     = W'($urandom);
         in_first = 1'($urandom);
         in_last  = 1'($urandom);
      end
      in_valid = pending;
      if (hold_armed && s2_cnt != 0) begin
         hold_armed = 1'b0;
         hold_left  = hold_len;
      end
      if (hold_left > 0) begin
         out_ready = 1'b0;
         hold_left--;
      end else begin
         out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      ack_rand = ($urandom_range(0, 99) < ack_pct);
      #1;
      commit  = (s1_cnt != 0) && ack_rand && (s2_cnt == 0 || out_ready);
      pop     = (s2_cnt != 0) && out_ready;
      exp_rdy = (s1_cnt == 0) || commit;
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("add_on_off", add_on_off, s1_cnt != 0);
      if (s1_cnt != 0) begin
         d = drv_q[0];
         check_eq("add_a", add_a, d[DRV_W-1 -: W]);
         check_eq("add_b", add_b, d[W+1 -: W]);
         check_eq("add_carry_listen", add_carry_listen, d[1]);
         if (d[1]) check_eq("add_carry_in", add_carry_in, d[0]);
      end else begin
         check_eq("adder_idle", {add_a, add_b, add_carry_in, add_carry_listen}, '0);
      end
      if (s2_cnt != 0) begin
         r = exp_q[0];
         check_eq("out_sum", out_sum, r[RES_W-1 -: W]);
         check_eq("out_carry", out_carry, r[IW+1]);
         check_eq("out_last", out_last, r[IW]);
         check_eq("out_idx", out_idx, r[IW-1:0]);
      end
      if (pop) begin
         void'(exp_q.pop_front());
         s2_cnt--;
      end
      if (commit) begin
         void'(drv_q.pop_front());
         s1_cnt--;
         s2_cnt++;
      end
      if (pending && exp_rdy) begin
         model_accept({in_a, in_b, in_first, in_last});
         s1_cnt++;
         pending = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      pending   = 1'b0;
      out_ready = 1'b0;
      ack_rand  = 1'b0;
      send_q.delete();
      repeat (n) @(negedge clk);
      exp_q.delete();
      drv_q.delete();
      s1_cnt = 0; s2_cnt = 0;
      m_busy = 1'b0; m_carry = 1'b0; m_err = 1'b0; m_next_idx = 0;
      hold_left = 0; hold_armed = 1'b0;
      check_eq("rst_in_ready", in_ready, 1'b0);
      check_eq("rst_outputs", {out_valid, out_sum, out_carry, out_last, out_idx, err_seq}, '0);
      check_eq("rst_adder", {add_a, add_b, add_carry_in, add_carry_listen, add_on_off}, '0);
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((send_q.size() > 0 || pending || s1_cnt != 0 || s2_cnt != 0) && n < budget) begin
         cycle();
         n++;
      end
      check_eq("drain_done", (send_q.size() > 0 || pending || s1_cnt != 0 || s2_cnt != 0), 1'b0);
   endtask

   task automatic set_full_rate();
      valid_pct = 100; ready_pct = 100; ack_pct = 100;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, len, n;
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0; ack_rand = 1'b0;
      n_vec = 0; n_err = 0; acc_total = 0; pending = 1'b0;
      hold_len = 0; hold_left = 0; hold_armed = 1'b0;
      set_full_rate();
      do_reset(2);

      // Single-chunk add with carry out.
      push_chunk(16'hFFFF, 16'h0001, 1'b1, 1'b1);
      drain(50);

      // 48-bit add streamed back to back.
      push_chunk(16'hFFFF, 16'h0001, 1'b1, 1'b0);
      push_chunk(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      push_chunk(16'h0000, 16'h0000, 1'b0, 1'b1);
      drain(50);

      // Same add with output held off for 3 cycles after the first result.
      hold_len = 3; hold_armed = 1'b1;
      push_chunk(16'hFFFF, 16'h0001, 1'b1, 1'b0);
      push_chunk(16'hFFFF, 16'h0000, 1'b0, 1'b0);
      push_chunk(16'h0000, 16'h0000, 1'b0, 1'b1);
      drain(50);
      hold_len = 0;

      // in_first on the second chunk of a running add.
      do_reset(1);
      push_chunk(16'h8001, 16'h8002, 1'b1, 1'b0);
      push_chunk(16'hFFF0, 16'h0010, 1'b1, 1'b0);
      push_chunk(16'h0005, 16'h0006, 1'b0, 1'b1);
      drain(50);
      check_eq("err_after_restart", err_seq, 1'b1);
      repeat (3) cycle();
      check_eq("err_sticky", err_seq, 1'b1);

      // Non-first chunk while idle.
      do_reset(1);
      push_chunk(16'h0007, 16'h0008, 1'b0, 1'b1);
      drain(50);
      check_eq("err_idle_nonfirst", err_seq, 1'b1);

      // Reset in the middle of a 3-chunk add, then a fresh add.
      do_reset(1);
      base = acc_total;
      push_chunk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      push_chunk(16'h1234, 16'h4321, 1'b0, 1'b0);
      push_chunk(16'h0001, 16'h0001, 1'b0, 1'b1);
      n = 0;
      while (acc_total < base + 2 && n < 20) begin
         cycle();
         n++;
      end
      check_eq("mid_op_accepts", acc_total - base, 2);
      do_reset(1);
      push_chunk(16'h0003, 16'h0004, 1'b1, 1'b1);
      drain(50);

      // Five chunks without in_last: the fifth restarts the chain.
      do_reset(1);
      for (int i = 0; i < 5; i++) push_chunk(16'hFFFF, 16'h0001, (i == 0), 1'b0);
      drain(50);
      check_eq("err_overflow", err_seq, 1'b1);

      // Randomized operations with random flow control and adder stalls.
      do_reset(1);
      for (int op = 0; op < 150; op++) begin
         if (op % 10 == 0) begin
            valid_pct = $urandom_range(50, 100);
            ready_pct = $urandom_range(30, 100);
            ack_pct   = $urandom_range(40, 100);
         end
         len = $urandom_range(1, 5);
         for (int c = 0; c < len; c++) begin
            logic f;
            f = (c == 0);
            if ($urandom_range(0, 99) < 5) f = !f;
            push_chunk(W'($urandom), W'($urandom), f, (c == len - 1));
         end
         if (op == 75) begin
            repeat ($urandom_range(2, 6)) cycle();
            do_reset($urandom_range(1, 2));
         end
         if (op % 10 == 9) drain(3000);
      end
      drain(3000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
